// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC stream engine: FSM state encoding
// and a small library of commonly used generator polynomials.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Generator polynomials with the implicit top term dropped.
  localparam logic [2:0]  CRC3_GSM_POLY    = 3'h3;
  localparam logic [4:0]  CRC5_POLY        = 5'h05;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update: folds one DATA_W-bit beat, MSB first, into the
// current CRC register value in a single evaluation.
module crc_step #(
  parameter int                DATA_W = 11,
  parameter int                CRC_W  = 5,
  parameter logic [CRC_W-1:0]  POLY   = CRC_W'(5'h05)
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);

  logic [CRC_W-1:0] w_acc;

  always_comb begin
    w_acc = i_crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ ((w_acc[CRC_W-1] ^ i_data[i]) ? POLY : '0);
    end
    o_crc = w_acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed CRC generator/checker: accumulates beats from sop to eop, then holds
// the result until the consumer takes it.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               DATA_W    = 11,
  parameter int               CRC_W     = 5,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC5_POLY),
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter int               MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              chk_en,
  input  logic [CRC_W-1:0]  chk_crc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_err,
  output logic              frame_err,
  output state_t            o_dbg_state
);

  localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  // Handshake: a beat transfers on a rising edge with in_valid && in_ready;
  // a result transfers with out_valid && out_ready. The two are exclusive.

  state_t           r_state, w_state_nxt;
  logic [CRC_W-1:0] r_crc, r_crc_out;
  logic [CRC_W-1:0] w_crc_base, w_crc_step, w_crc_final;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_crc_err, r_frame_err;
  logic             w_accept, w_load, w_done, w_frame_err;

  crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step (
    .i_crc  (w_crc_base),
    .i_data (in_data),
    .o_crc  (w_crc_step)
  );

  always_comb begin
    w_accept    = in_valid && (r_state != ST_HOLD);
    w_crc_base  = in_sop ? INIT : r_crc;
    w_cnt_nxt   = in_sop ? CNT_W'(1) : r_cnt + 1'b1;
    w_crc_final = w_crc_step ^ XOR_OUT;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_accept) begin
          if (!in_sop && (r_state == ST_IDLE)) begin
            w_frame_err = 1'b1;
          end else begin
            // A sop mid-frame aborts the old frame and restarts on this beat.
            if (in_sop && (r_state == ST_ACCUM)) w_frame_err = 1'b1;
            w_load = 1'b1;
            if (in_eop) begin
              w_done      = 1'b1;
              w_state_nxt = ST_HOLD;
            end else if (w_cnt_nxt == MAX_CNT) begin
              w_frame_err = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_ACCUM;
            end
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state     <= ST_IDLE;
      r_crc       <= INIT;
      r_cnt       <= '0;
      r_crc_out   <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_frame_err;
      if (w_load) begin
        r_crc <= w_crc_step;
        r_cnt <= w_cnt_nxt;
      end
      if (w_done) begin
        r_crc_out <= w_crc_final;
        r_crc_err <= chk_en && (w_crc_final != chk_crc);
      end
    end
  end

  assign in_ready    = (r_state != ST_HOLD);
  assign out_valid   = (r_state == ST_HOLD);
  assign crc_out     = r_crc_out;
  assign crc_err     = r_crc_err;
  assign frame_err   = r_frame_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: directed frames plus randomized framing, with
// results checked against a polynomial long-division reference model.
module tb_crc_stream_engine;
  import crc_pkg::*;

  localparam int DW = 11;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          chk_en = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] chk_crc = '0;
  logic          in_ready, out_valid, crc_err, frame_err;
  logic [CW-1:0] crc_out;
  state_t        dbg_state;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [CW:0]   exp_q[$];
  int            exp_fe = 0;
  int            fe_seen = 0;
  int            viol = 0;
  int            rdy_mode = 1;
  logic [DW-1:0] fd[4];
  logic          hold_pending = 1'b0;
  logic [CW:0]   held = '0;

  crc_stream_engine #(
    .DATA_W(DW), .CRC_W(CW), .POLY(5'h05), .INIT(5'h00), .XOR_OUT(5'h00), .MAX_BEATS(4)
  ) dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .chk_en(chk_en),
    .chk_crc(chk_crc), .out_valid(out_valid), .out_ready(out_ready),
    .crc_out(crc_out), .crc_err(crc_err), .frame_err(frame_err),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: CRC with zero init is the remainder of M(x)*x^5 mod G(x).
  function automatic logic [CW-1:0] ref_crc(input int n);
    bit          b[$];
    logic [CW:0] g;
    logic [CW-1:0] r;
    g = {1'b1, 5'h05};
    for (int i = 0; i < n; i++)
      for (int k = DW - 1; k >= 0; k--) b.push_back(fd[i][k]);
    for (int k = 0; k < CW; k++) b.push_back(1'b0);
    for (int i = 0; i < b.size() - CW; i++)
      if (b[i]) for (int j = 0; j <= CW; j++) b[i+j] ^= g[CW-j];
    for (int k = 0; k < CW; k++) r[CW-1-k] = b[b.size()-CW+k];
    return r;
  endfunction

  // Consumer: out_ready changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_L) begin
        if (frame_err) fe_seen++;
        if (in_ready && out_valid) viol++;
        if (out_valid) begin
          if (hold_pending) check("hold_stable", 32'({crc_err, crc_out}), 32'(held));
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_result: got %0h expected none", {crc_err, crc_out});
            end else begin
              check("result", 32'({crc_err, crc_out}), 32'(exp_q.pop_front()));
            end
            hold_pending = 1'b0;
          end else begin
            held = {crc_err, crc_out};
            hold_pending = 1'b1;
          end
        end else begin
          hold_pending = 1'b0;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e,
                           input logic ce, input logic [CW-1:0] cc);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; chk_en = ce; chk_crc = cc;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; chk_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_crc_out", 32'(crc_out), 32'd0);
    check("rst_crc_err", 32'(crc_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_L = 1'b1;
  endtask

  task automatic send_frame(input int n, input bit with_eop, input bit ce, input bit bad);
    logic [CW-1:0] c, cc;
    for (int i = 0; i < n; i++) fd[i] = DW'($urandom);
    c  = ref_crc(n);
    cc = bad ? (c ^ CW'($urandom_range(1, 31))) : c;
    if (with_eop) exp_q.push_back({ce && bad, c});
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 1));
      send_beat(fd[i], i == 0, with_eop && (i == n - 1), ce, cc);
    end
  endtask

  initial begin
    int kind;
    reset_L = 1'b0;
    idle(3);
    check("init_state", 32'(dbg_state), 32'(ST_IDLE));
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_crc_out", 32'(crc_out), 32'd0);
    reset_L = 1'b1;
    idle(1);
    check("init_in_ready", 32'(in_ready), 32'd1);

    // Single beat 0x001 with one-cycle latency.
    exp_q.push_back({1'b0, 5'h05});
    send_beat(11'h001, 1'b1, 1'b1, 1'b0, 5'h00);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Stalled consumer: result and in_ready=0 held steady.
    rdy_mode = 2;
    exp_q.push_back({1'b0, 5'h0A});
    send_beat(11'h002, 1'b1, 1'b1, 1'b0, 5'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_crc_out", 32'(crc_out), 32'h0A);
    end
    rdy_mode = 1;
    drain();

    // Two-beat frame: generate, check good, check bad.
    exp_q.push_back({1'b0, 5'h1B});
    send_beat(11'h001, 1'b1, 1'b0, 1'b0, 5'h00);
    send_beat(11'h000, 1'b0, 1'b1, 1'b0, 5'h00);
    exp_q.push_back({1'b0, 5'h1B});
    send_beat(11'h001, 1'b1, 1'b0, 1'b0, 5'h00);
    send_beat(11'h000, 1'b0, 1'b1, 1'b1, 5'h1B);
    exp_q.push_back({1'b1, 5'h1B});
    send_beat(11'h001, 1'b1, 1'b0, 1'b0, 5'h00);
    send_beat(11'h000, 1'b0, 1'b1, 1'b1, 5'h1A);
    drain();

    // Abort by a second sop.
    exp_q.push_back({1'b0, 5'h0A});
    send_beat(11'h001, 1'b1, 1'b0, 1'b0, 5'h00);
    exp_fe++;
    send_beat(11'h002, 1'b1, 1'b1, 1'b0, 5'h00);
    drain();
    idle(3);
    check("abort_frame_err", fe_seen, exp_fe);

    // Stray beat in IDLE, then an overrun frame.
    exp_fe++;
    send_beat(11'h123, 1'b0, 1'b0, 1'b0, 5'h00);
    idle(3);
    check("stray_frame_err", fe_seen, exp_fe);
    send_beat(11'h055, 1'b1, 1'b0, 1'b0, 5'h00);
    for (int i = 0; i < 3; i++) send_beat(11'h3A5, 1'b0, 1'b0, 1'b0, 5'h00);
    exp_fe++;
    idle(3);
    check("overrun_frame_err", fe_seen, exp_fe);
    check("overrun_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("overrun_no_result", 32'(out_valid), 32'd0);

    // Reset mid-frame and in HOLD.
    send_beat(11'h001, 1'b1, 1'b0, 1'b0, 5'h00);
    do_reset();
    exp_q.push_back({1'b0, 5'h05});
    send_beat(11'h001, 1'b1, 1'b1, 1'b0, 5'h00);
    drain();
    rdy_mode = 2;
    send_beat(11'h002, 1'b1, 1'b1, 1'b0, 5'h00);
    idle(1);
    do_reset();
    rdy_mode = 1;
    exp_q.push_back({1'b0, 5'h05});
    send_beat(11'h001, 1'b1, 1'b1, 1'b0, 5'h00);
    drain();
    idle(3);
    check("reset_no_frame_err", fe_seen, exp_fe);

    // Randomized framing with a random consumer.
    rdy_mode = 0;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          send_frame(4, 1'b0, 1'b0, 1'b0);
          exp_fe++;
        end
        1: begin
          send_frame($urandom_range(1, 3), 1'b0, 1'b0, 1'b0);
          exp_fe++;
          send_frame($urandom_range(1, 4), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        2: begin
          exp_fe++;
          send_beat(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 5'h00);
        end
        default: send_frame($urandom_range(1, 4), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end
    drain();
    idle(3);
    check("final_frame_err_count", fe_seen, exp_fe);
    check("ready_valid_exclusive", viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 Parameter DATA_W, default 11: bits per input beat, range 1..64.
REQ-002 Parameter CRC_W, default 5: CRC register width, range 3..16.
REQ-003 Parameter POLY, default 5'h05: generator polynomial without the implicit x^CRC_W term (x^5+x^2+1).
REQ-004 Parameter INIT, default 0: CRC register value loaded at frame start.
REQ-005 Parameter XOR_OUT, default 0: value XORed onto the final register to form crc_out.
REQ-006 Parameter MAX_BEATS, default 16: maximum beats per frame.
REQ-007 clk  input  1  sole clock; all state changes on rising edge.
REQ-008 reset_L  input  1  reset, synchronous, active-low.
REQ-009 in_valid  input  1  input beat offered.
REQ-010 in_ready  output  1  engine accepts a beat this cycle.
REQ-011 in_data  input  DATA_W  beat payload.
REQ-012 in_sop  input  1  first beat of frame.
REQ-013 in_eop  input  1  last beat of frame.
REQ-014 chk_en  input  1  sampled with the eop beat; 1 = check mode, 0 = generate mode.
REQ-015 chk_crc  input  CRC_W  expected CRC, sampled with the eop beat.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer takes result.
REQ-018 crc_out  output  CRC_W  final CRC (register XOR XOR_OUT).
REQ-019 crc_err  output  1  check mode: crc_out != chk_crc; 0 in generate mode.
REQ-020 frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-021 Beat accepted when in_valid && in_ready.
REQ-022 Per accepted beat, bits shift in MSB first (in_data[DATA_W-1] first): fb = c[CRC_W-1]^bit; c = (c<<1) ^ (fb ? POLY : 0), all DATA_W steps in one cycle.
REQ-023 FSM states IDLE, ACCUM, HOLD; reset state IDLE.
REQ-024 IDLE: in_ready=1; beat with in_sop starts frame from INIT and goes to ACCUM, or straight to HOLD if in_eop also set.
REQ-025 IDLE: beat without in_sop is dropped and pulses frame_err.
REQ-026 ACCUM: in_ready=1; beat without sop accumulates; eop beat goes to HOLD.
REQ-027 ACCUM: beat with in_sop aborts the current frame, pulses frame_err, restarts from INIT with that beat (eop on same beat -> HOLD).
REQ-028 Beat counter counts accepted beats per frame; reaching MAX_BEATS without eop pulses frame_err and returns to IDLE, frame discarded, no output.
REQ-029 HOLD: in_ready=0, out_valid=1, crc_out/crc_err stable until out_valid && out_ready, then IDLE.
REQ-030 Latency: out_valid asserts the cycle after the eop beat is accepted.
REQ-031 in_ready and out_valid are never both 1; no new beat is accepted in the cycle the result is consumed.
REQ-032 Register arithmetic is modulo 2 on CRC_W bits; chk_crc compared on all CRC_W bits.

Reset
REQ-033 With reset_L=0 at a clock edge: state IDLE, CRC register=INIT, beat counter=0, out_valid=0, crc_out=0, crc_err=0, frame_err=0; in_ready=1 from the first cycle after reset.
REQ-034 Reset mid-frame or in HOLD discards the frame and its pending result without frame_err.

Structure
REQ-035 Shared package crc_pkg holds the FSM state typedef and named polynomial constants (CRC5_POLY=5'h05 and others).
REQ-036 Combinational sub-module crc_step (parameters DATA_W, CRC_W, POLY) computes next CRC from current CRC and one beat; for DATA_W=11, CRC_W=5, POLY=5'h05 it equals the existing 11-bit CRC-5 equations.

Verification
REQ-037 Defaults, single beat sop+eop in_data=11'h001, chk_en=0 -> next cycle out_valid=1, crc_out=5'h05, crc_err=0.
REQ-038 Single beat in_data=11'h002 -> crc_out=5'h0A; out_ready held 0 for 3 cycles -> output stable, in_ready=0 throughout.
REQ-039 Two beats 11'h001 (sop), 11'h000 (eop) -> crc_out=5'h1B; repeat with chk_en=1, chk_crc=5'h1B -> crc_err=0; chk_crc=5'h1A -> crc_err=1.
REQ-040 Frame 11'h001 (sop), then 11'h002 with sop+eop -> frame_err pulse, crc_out=5'h0A.
REQ-041 Beat without sop in IDLE -> frame_err pulse, no out_valid; MAX_BEATS=4, four beats without eop -> frame_err, IDLE, no out_valid.
REQ-042 reset_L=0 for one cycle during ACCUM and during HOLD -> all outputs at reset values, next frame 11'h001 gives 5'h05.
